// File: rtl/conv3x3_window_mul.sv
// conv3x3_window_mul
//   Forms a 3x3 sliding window over a raster-ordered 8-bit pixel stream using two
//   line buffers. It multiplies the window by nine stored signed 8-bit weights and
//   presents nine registered 16-bit signed products for a 9-input adder tree.
//   Only unpadded windows are emitted, so the output map is (IMG_W-2) x (IMG_H-2).
//   Latency is two cycles from an accepted pixel to valid_out. There is no backpressure.
//   Optional build macro PIX_UNSIGNED_EN: when defined, pix_in is treated as
//   unsigned 0..255. Otherwise pix_in is treated as signed INT8. Weights are signed
//   in both cases.

module conv3x3_window_mul #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [7:0]  pix_in,
  input  logic        w_load,
  input  logic [3:0]  w_idx,
  input  logic [7:0]  w_data,
  output logic        valid_out,
  output logic [15:0] p0,
  output logic [15:0] p1,
  output logic [15:0] p2,
  output logic [15:0] p3,
  output logic [15:0] p4,
  output logic [15:0] p5,
  output logic [15:0] p6,
  output logic [15:0] p7,
  output logic [15:0] p8,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  // Raster position of the pixel currently on pix_in.
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;

  // linebuf1 holds the previous row and linebuf0 holds the row before that.
  logic [7:0] linebuf0 [IMG_W];
  logic [7:0] linebuf1 [IMG_W];

  // The window is indexed [row][tap]. Row 0 is the oldest row and tap 0 is the oldest column.
  logic [7:0] win_reg [3][3];

  logic [7:0]  weight_reg [9];
  logic [15:0] prod_comb  [9];
  logic [15:0] prod_reg   [9];

  // Pipeline flags travelling alongside the window and product stages.
  logic win_valid_reg, win_valid_next;
  logic win_last_reg, win_last_next;
  logic valid_out_reg;
  logic frame_done_reg;

  // Advance the raster position on each accepted pixel, wrapping at row and frame ends.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (valid_in) begin
      if (col_reg == COL_LAST) begin
        col_next = '0;
        row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
      end else begin
        col_next = col_reg + 1'b1;
      end
    end
  end

  // A window is complete once the accepted pixel has two full rows and columns behind it.
  always_comb begin
    win_valid_next = valid_in && (row_reg >= ROW_MIN) && (col_reg >= COL_MIN);
    win_last_next  = valid_in && (row_reg == ROW_LAST) && (col_reg == COL_LAST);
  end

  // Position counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // Line buffers shift one row down in place. The read happens before the write, so the RAM needs no reset.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      linebuf0[col_reg] <= linebuf1[col_reg];
      linebuf1[col_reg] <= pix_in;
    end
  end

  // The window shifts left on accept. The newest taps are the registered line-buffer reads and the new pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_reg[r][0] <= win_reg[r][1];
        win_reg[r][1] <= win_reg[r][2];
      end
      win_reg[0][2] <= linebuf0[col_reg];
      win_reg[1][2] <= linebuf1[col_reg];
      win_reg[2][2] <= pix_in;
    end
  end

  // Weight file. Indices above 8 match no entry and are therefore ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        weight_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (w_load && (w_idx == 4'(i))) begin
          weight_reg[i] <= w_data;
        end
      end
    end
  end

  // Nine multipliers. Operands are extended to 16 bits, so the low 16 bits of the product are exact.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : gen_mul
      logic [7:0]         tap;
      logic signed [15:0] pix_ext;
      logic signed [15:0] wgt_ext;
      assign tap = win_reg[gi / 3][gi % 3];
`ifdef PIX_UNSIGNED_EN
      assign pix_ext = {8'd0, tap};
`else
      assign pix_ext = {{8{tap[7]}}, tap};
`endif
      assign wgt_ext = {{8{weight_reg[gi][7]}}, weight_reg[gi]};
      assign prod_comb[gi] = pix_ext * wgt_ext;
    end
  endgenerate

  // Product registers capture only complete windows and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        prod_reg[i] <= '0;
      end
    end else if (win_valid_reg) begin
      for (int i = 0; i < 9; i++) begin
        prod_reg[i] <= prod_comb[i];
      end
    end
  end

  // Valid and frame-end flags follow the data through both stages. Reset drops any in-flight window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid_reg  <= 1'b0;
      win_last_reg   <= 1'b0;
      valid_out_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      win_valid_reg  <= win_valid_next;
      win_last_reg   <= win_last_next;
      valid_out_reg  <= win_valid_reg;
      frame_done_reg <= win_valid_reg && win_last_reg;
    end
  end

  assign valid_out  = valid_out_reg;
  assign frame_done = frame_done_reg;
  assign p0 = prod_reg[0];
  assign p1 = prod_reg[1];
  assign p2 = prod_reg[2];
  assign p3 = prod_reg[3];
  assign p4 = prod_reg[4];
  assign p5 = prod_reg[5];
  assign p6 = prod_reg[6];
  assign p7 = prod_reg[7];
  assign p8 = prod_reg[8];

endmodule

// File: tb/tb_conv3x3_window_mul.sv
// Scoreboard bench for conv3x3_window_mul on a 6x4 image.
// Stimulus pushes expected windows into a queue, and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_conv3x3_window_mul;
  localparam int W = 6;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  pix_in = '0;
  logic        w_load = 1'b0;
  logic [3:0]  w_idx = '0;
  logic [7:0]  w_data = '0;
  logic        valid_out, frame_done;
  logic [15:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic [8:0][15:0] p_act;

  always #5 clk = ~clk;

  conv3x3_window_mul #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .pix_in(pix_in),
    .w_load(w_load), .w_idx(w_idx), .w_data(w_data),
    .valid_out(valid_out),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .frame_done(frame_done)
  );

  assign p_act = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

  typedef struct packed {
    logic [8:0][15:0] p;
    logic             last;
    logic [31:0]      due;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rst_q;
  exp_t sb [$];
  exp_t mon_e;
  logic [8:0][15:0] last_exp = '0;
  logic [8:0][15:0] cap_p = '0;
  bit   cap_arm = 1'b0;
  int   n_valid = 0;
  int   n_done = 0;

  // Reference model state used by the stimulus side.
  int m_img [W*H];
  int m_w [9];
  int m_row = 0;
  int m_col = 0;

  // Count cycles and remember whether reset was sampled at this edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor: compare outputs with the scoreboard at every negedge.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst_q) begin
        sb.delete();
        last_exp = '0;
        checks++;
        if (valid_out !== 1'b0 || frame_done !== 1'b0 || p_act !== '0) begin
          errors++;
          $display("FAIL reset_state: valid_out=%b frame_done=%b p=%h, expected all zero", valid_out, frame_done, p_act);
        end
      end else begin
        while (sb.size() > 0 && int'(sb[0].due) < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_output: window due at cycle %0d not seen (now %0d)", sb[0].due, cyc);
          void'(sb.pop_front());
        end
        if (valid_out === 1'b1) begin
          n_valid++;
          if (frame_done === 1'b1) n_done++;
          if (cap_arm) begin
            cap_p   = p_act;
            cap_arm = 1'b0;
          end
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, expected no output", cyc);
          end else begin
            mon_e = sb.pop_front();
            checks++;
            if (int'(mon_e.due) != cyc) begin
              errors++;
              $display("FAIL latency: output at cycle %0d, expected cycle %0d", cyc, mon_e.due);
            end
            for (int k = 0; k < 9; k++) begin
              checks++;
              if (p_act[k] !== mon_e.p[k]) begin
                errors++;
                $display("FAIL p%0d: got %0d, expected %0d (cycle %0d)", k, $signed(p_act[k]), $signed(mon_e.p[k]), cyc);
              end
            end
            checks++;
            if (frame_done !== mon_e.last) begin
              errors++;
              $display("FAIL frame_done: got %b, expected %b (cycle %0d)", frame_done, mon_e.last, cyc);
            end
            last_exp = mon_e.p;
            $display("window out cycle %0d: p0=%0d p4=%0d p8=%0d last=%b", cyc, $signed(p_act[0]), $signed(p_act[4]), $signed(p_act[8]), frame_done);
          end
        end else begin
          checks++;
          if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL frame_done_idle: got %b, expected 0 (cycle %0d)", frame_done, cyc);
          end
          checks++;
          if (p_act !== last_exp) begin
            errors++;
            $display("FAIL hold: p=%h, expected held %h (cycle %0d)", p_act, last_exp, cyc);
          end
        end
      end
    end
  end

  function automatic int pix_val(input logic [7:0] px);
`ifdef PIX_UNSIGNED_EN
    return int'(px);
`else
    return int'($signed(px));
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, update the model, and push any completed window.
  task automatic drive(input logic v, input logic [7:0] px, input logic wl,
                       input logic [3:0] wi, input logic [7:0] wd);
    exp_t e;
    int   r, c;
    tick();
    valid_in = v;
    pix_in   = px;
    w_load   = wl;
    w_idx    = wi;
    w_data   = wd;
    if (wl && wi <= 4'd8) m_w[wi] = int'($signed(wd));
    if (v) begin
      m_img[m_row*W + m_col] = pix_val(px);
      if (m_row >= 2 && m_col >= 2) begin
        for (int k = 0; k < 9; k++) begin
          r = m_row - 2 + k / 3;
          c = m_col - 2 + k % 3;
          e.p[k] = 16'(m_img[r*W + c] * m_w[k]);
        end
        e.last = (m_row == H-1) && (m_col == W-1);
        e.due  = 32'(cyc + 2);
        sb.push_back(e);
      end
      if (m_col == W-1) begin
        m_col = 0;
        m_row = (m_row == H-1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
  endtask

  task automatic send(input logic [7:0] px);
    drive(1'b1, px, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic load_w(input logic [3:0] i, input logic [7:0] d);
    drive(1'b0, 8'd0, 1'b1, i, d);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    valid_in = 1'b0;
    w_load = 1'b0;
    m_row = 0;
    m_col = 0;
    for (int k = 0; k < 9; k++) m_w[k] = 0;
    tick();
    rst = 1'b0;
  endtask

  // Stream raster-index pixels 0..23, optionally with an idle cycle after each pixel.
  task automatic frame(input bit gaps);
    for (int i = 0; i < W*H; i++) begin
      send(8'(i));
      if (gaps) drive(1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
    end
  endtask

  task automatic drain(input string name);
    drive(1'b0, 8'd0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout: %0d windows outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic expect_count(input string name, input int got_v, input int got_d, input int req_v, input int req_d);
    checks++;
    if (got_v != req_v || got_d != req_d) begin
      errors++;
      $display("FAIL %s count: valid_out=%0d frame_done=%0d, expected %0d and %0d", name, got_v, got_d, req_v, req_d);
    end
  endtask

  task automatic hand_check(input string name, input logic [8:0][15:0] req);
    checks++;
    if (cap_arm) begin
      errors++;
      $display("FAIL %s capture: no window observed, expected one", name);
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (cap_p[k] !== req[k]) begin
        errors++;
        $display("FAIL %s p%0d: got %0d, expected %0d", name, k, $signed(cap_p[k]), $signed(req[k]));
      end
    end
  endtask

  int hand1 [9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
  logic [8:0][15:0] req;
  int sv, sd;

  initial begin
    for (int k = 0; k < 9; k++) m_w[k] = 0;
    for (int k = 0; k < 9; k++) req[k] = 16'(hand1[k]);
    do_reset();

    // After reset with no weights loaded, every product is zero.
    cap_arm = 1'b1;
    frame(1'b0);
    drain("t5a");
    hand_check("t5a_zero", '0);

    // Test 1: unit weights and back-to-back raster stream.
    for (int i = 0; i < 9; i++) load_w(4'(i), 8'd1);
    sv = n_valid; sd = n_done; cap_arm = 1'b1;
    frame(1'b0);
    drain("t1");
    expect_count("t1", n_valid - sv, n_done - sd, 8, 1);
    hand_check("t1_first", req);

    // Test 2: same stream with valid_in toggling.
    sv = n_valid; sd = n_done; cap_arm = 1'b1;
    frame(1'b1);
    drain("t2");
    expect_count("t2", n_valid - sv, n_done - sd, 8, 1);
    hand_check("t2_first", req);

    // Test 5b: out-of-range weight indices are ignored.
    for (int i = 9; i < 16; i++) load_w(4'(i), 8'h55);
    sv = n_valid; sd = n_done; cap_arm = 1'b1;
    frame(1'b0);
    drain("t5b");
    expect_count("t5b", n_valid - sv, n_done - sd, 8, 1);
    hand_check("t5b_first", req);

    // Test 3: weights -128 are loaded in the same cycles as the first nine pixels of -128.
    cap_arm = 1'b1;
    for (int i = 0; i < W*H; i++) drive(1'b1, 8'h80, i < 9, 4'(i), 8'h80);
    drain("t3a");
`ifdef PIX_UNSIGNED_EN
    for (int k = 0; k < 9; k++) req[k] = 16'hC000;
`else
    for (int k = 0; k < 9; k++) req[k] = 16'h4000;
`endif
    hand_check("t3_neg_sq", req);
    load_w(4'd4, 8'h7F);
    cap_arm = 1'b1;
    for (int i = 0; i < W*H; i++) send(8'h80);
    drain("t3b");
`ifdef PIX_UNSIGNED_EN
    req[4] = 16'h3F80;
`else
    req[4] = 16'hC080;
`endif
    hand_check("t3_w127", req);

    // Test 4: reset mid-frame while windows are in flight, then reset after 10 pixels.
    for (int i = 0; i < 16; i++) send(8'(i));
    do_reset();
    for (int i = 0; i < 10; i++) send(8'(i));
    do_reset();
    for (int i = 0; i < 9; i++) load_w(4'(i), 8'd1);
    for (int k = 0; k < 9; k++) req[k] = 16'(hand1[k]);
    sv = n_valid; sd = n_done; cap_arm = 1'b1;
    frame(1'b0);
    drain("t4");
    expect_count("t4", n_valid - sv, n_done - sd, 8, 1);
    hand_check("t4_first", req);

    // Test 6: pixel 0xFF with weight 0x7F.
    for (int i = 0; i < 9; i++) load_w(4'(i), 8'h7F);
    cap_arm = 1'b1;
    for (int i = 0; i < W*H; i++) send(8'hFF);
    drain("t6");
`ifdef PIX_UNSIGNED_EN
    for (int k = 0; k < 9; k++) req[k] = 16'd32385;
`else
    for (int k = 0; k < 9; k++) req[k] = 16'hFF81;
`endif
    hand_check("t6_ff", req);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
